// File: rtl/dmem_pkg.sv
// Shared types and sizing constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES  = 4;
  localparam int BYTE_W      = 8;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed synchronous RAM with per-byte write mask and a registered read port.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           wr,
  input  logic                           rd,
  input  logic [ADDR_WIDTH-1:0]          idx,
  input  logic [WORD_BYTES-1:0]          mask,
  input  logic [WORD_BYTES*BYTE_W-1:0]   wdata,
  output logic [WORD_BYTES*BYTE_W-1:0]   rdata
);

  logic [WORD_BYTES*BYTE_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (mask[i]) mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (rd) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: req/ack handshake, LATENCY wait states, byte-masked RAM access.
// Optional DMEM_ALIGN_CHECK_EN flags accesses with addr[1:0] != 0 via err and suppresses them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             go_resp;
  logic             accept;

  logic             cap_we;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_be;

  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic             mis;
  logic             rd_vld;
  logic [31:0]      ram_q;
  logic             unused_addr;

  assign accept = (state == IDLE) && req;

  always_comb begin
    state_nxt = state;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LAT_CNT == '0) begin
            state_nxt = RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the access commits on the accepting edge, before capture lands.
  always_comb begin
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_be    = be;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (acc_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign unused_addr = ^{acc_addr[31:ADDR_WIDTH+2], acc_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
      rd_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack    <= go_resp;
      err    <= go_resp & mis;
      rd_vld <= go_resp & ~acc_we & ~mis;
      if (accept)              cnt <= LAT_CNT;
      else if (state == WAIT)  cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= we;
      cap_addr  <= addr;
      cap_wdata <= wdata;
      cap_be    <= be;
    end
  end

  dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .wr    (go_resp & acc_we & ~mis),
    .rd    (go_resp & ~acc_we),
    .idx   (acc_addr[ADDR_WIDTH+1:2]),
    .mask  (acc_be),
    .wdata (acc_wdata),
    .rdata (ram_q)
  );

  // Read data is only driven during the ack cycle of a good read.
  assign rdata = rd_vld ? ram_q : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 and one at LATENCY=0 sharing clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ack, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = '0;
  logic        ack0, err0;
  logic [31:0] rdata0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack), .rdata(rdata), .err(err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request on the LATENCY=2 instance; edges counts the accepting edge as 1.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output int edges,
                     output logic [31:0] rd, output logic e);
    logic got;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    edges = 0; got = 1'b0; rd = '0; e = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (ack) begin
        got = 1'b1; rd = rdata; e = err;
      end
    end
    req = 1'b0;
    chk("ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  int          n;
  logic [31:0] r;
  logic        e;
  int          acks;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full write then read, latency check
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, n, r, e);
    chk("wr_edges", n, 32'd3);
    chk("wr_rdata_zero", r, 32'h0);
    chk("wr_err", {31'b0, e}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, n, r, e);
    chk("rd_edges", n, 32'd3);
    chk("rd_data", r, 32'hDEADBEEF);
    chk("rd_err", {31'b0, e}, 32'd0);
    @(posedge clk); #1;
    chk("rdata_idle_zero", rdata, 32'h0);

    // Byte enables, including an all-off write
    txn(1'b1, 32'h20, 32'h11223344, 4'b1111, n, r, e);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, n, r, e);
    txn(1'b0, 32'h20, 32'h0, 4'b0000, n, r, e);
    chk("be_0101", r, 32'h11BB33DD);
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, n, r, e);
    chk("be_0000_edges", n, 32'd3);
    txn(1'b0, 32'h20, 32'h0, 4'b1111, n, r, e);
    chk("be_0000_nochg", r, 32'h11BB33DD);
    txn(1'b1, 32'h20, 32'h99887766, 4'b1000, n, r, e);
    txn(1'b0, 32'h20, 32'h0, 4'b0001, n, r, e);
    chk("be_1000", r, 32'h99BB33DD);

    // Address wrap: 0x1000 aliases word 0
    txn(1'b1, 32'h1000, 32'h00000FFF, 4'b1111, n, r, e);
    txn(1'b0, 32'h0, 32'h0, 4'b1111, n, r, e);
    chk("wrap", r, 32'h00000FFF);

    // Misaligned accesses
    txn(1'b1, 32'h30, 32'hCAFEF00D, 4'b1111, n, r, e);
    txn(1'b1, 32'h32, 32'h12345678, 4'b1111, n, r, e);
    chk("mis_wr_edges", n, 32'd3);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_wr_err", {31'b0, e}, 32'd1);
`else
    chk("mis_wr_err", {31'b0, e}, 32'd0);
`endif
    txn(1'b0, 32'h30, 32'h0, 4'b1111, n, r, e);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_wr_data", r, 32'hCAFEF00D);
`else
    chk("mis_wr_data", r, 32'h12345678);
`endif
    chk("mis_rd_aligned_err", {31'b0, e}, 32'd0);
    txn(1'b0, 32'h31, 32'h0, 4'b1111, n, r, e);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_rd_data", r, 32'h0);
    chk("mis_rd_err", {31'b0, e}, 32'd1);
`else
    chk("mis_rd_data", r, 32'h12345678);
    chk("mis_rd_err", {31'b0, e}, 32'd0);
`endif

    // Reset during WAIT of a write drops it
    txn(1'b1, 32'h40, 32'h0BADF00D, 4'b1111, n, r, e);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h55555555; be = 4'b1111;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ack", {31'b0, ack}, 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("midrst_no_ack", acks, 32'd0);
    txn(1'b0, 32'h40, 32'h0, 4'b1111, n, r, e);
    chk("midrst_old_data", r, 32'h0BADF00D);

    // Zero latency with req held high: ack, idle, ack, ...
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h600DCAFE; be0 = 4'b1111;
    @(posedge clk); #1;
    chk("l0_wr_ack", {31'b0, ack0}, 32'd1);
    chk("l0_wr_rdata", rdata0, 32'h0);
    we0 = 1'b0;
    @(posedge clk); #1;
    chk("l0_idle", {31'b0, ack0}, 32'd0);
    @(posedge clk); #1;
    chk("l0_rd_ack", {31'b0, ack0}, 32'd1);
    chk("l0_rd_data", rdata0, 32'h600DCAFE);
    chk("l0_rd_err", {31'b0, err0}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("l0_pattern", {31'b0, ack0}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    req0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("l0_stop", {31'b0, ack0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
